pong_game_fsm: RTL and testbench
================================

Name: pong_game_fsm

Overview:
- Downstream consumer of the collision stage.
- Turns its level-type paddle-hit and miss flags into single events, keeps both players' scores and runs the serve/rally/pause/game-over sequence.
- Drives the ball-movement enable, the serve strobe and direction, and a rally speed level back to the ball and paddle logic.
- Clocked at the system clock; frame pacing comes from a one-cycle frame_tick strobe.

Parameters:
- SCORE_W, 4, width of each score counter.
- WIN_SCORE, 11, score that ends the game; must be < 2**SCORE_W.
- PAUSE_FRAMES, 60, frame_tick count spent in PAUSE after a point; must be ≥ 1.
- PAUSE_W, 6, width of the pause counter; 2**PAUSE_W > PAUSE_FRAMES.
- HITS_PER_LEVEL, 4, paddle hits per speed level step; must be ≥ 1.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- frame_tick, input, 1, one-cycle strobe per video frame.
- start, input, 1, start/restart button level, already synchronised.
- paddle_hit, input, 1, level: ball touching either paddle.
- miss_p1, input, 1, level: ball passed player 1; player 2 scores.
- miss_p2, input, 1, level: ball passed player 2; player 1 scores.
- score1, output, SCORE_W, player 1 score.
- score2, output, SCORE_W, player 2 score.
- ball_en, output, 1, ball movement enable.
- serve_pulse, output, 1, one-cycle strobe to relaunch the ball from centre.
- serve_dir, output, 1, launch direction: 0 = toward player 1, 1 = toward player 2.
- speed_lvl, output, 2, rally speed level, 0..3.
- game_over, output, 1, high while in GAME_OVER.
- winner, output, 1, 0 = player 1, 1 = player 2; valid while game_over = 1.

Behaviour:
- Reset: one clock, clk. Reset rst_n is asynchronous, active-low; assertion takes effect immediately regardless of clk.
- Reset values, all registered outputs:
  - State IDLE.
  - score1 = score2 = 0; ball_en = 0; serve_pulse = 0; serve_dir = 0; speed_lvl = 0; game_over = 0; winner = 0.
  - Rally counter and pause counter = 0; edge-detect history registers = 0.
  - Reset mid-game discards everything; no state survives.
- Edge detection:
  - start, paddle_hit, miss_p1 and miss_p2 each have a history register, updated every cycle in all states.
  - Event = current level & ~previous level.
  - A level held for many cycles yields exactly one event.
  - Events are acted on only in the states listed below; elsewhere they are dropped.
- Latency: an event sampled at edge N is reflected in registered outputs immediately after edge N.
- IDLE:
  - ball_en = 0.
  - start event → clear scores, serve_dir = 0, go to SERVE.
- SERVE (exactly one cycle):
  - serve_pulse = 1, ball_en = 0.
  - Clear the rally counter and speed_lvl.
  - Next state PLAY.
- PLAY:
  - ball_en = 1.
  - paddle_hit event → rally counter +1, mod HITS_PER_LEVEL. On wrap to 0, speed_lvl +1, saturating at 3.
  - Exactly one miss event:
    - The opposing score increments.
    - serve_dir points toward the player who conceded: miss_p1 → 0, miss_p2 → 1.
    - ball_en = 0 from the next cycle.
    - If the new score equals WIN_SCORE → GAME_OVER, winner = scorer. Otherwise → PAUSE with the pause counter cleared.
  - Both miss events in the same cycle: no score change, serve_dir unchanged, → PAUSE.
  - A miss event and a paddle_hit event in the same cycle: the miss wins; the hit is ignored.
- PAUSE:
  - ball_en = 0.
  - Pause counter increments on frame_tick.
  - When the counter reaches PAUSE_FRAMES → SERVE.
  - start, miss and paddle events are ignored.
- GAME_OVER:
  - game_over = 1; winner, scores and ball_en = 0 are held.
  - start event → clear scores, game_over = 0, go to SERVE with serve_dir = winner's opponent's side.
- Scores never exceed WIN_SCORE; no wrap-around is possible.
- serve_pulse is never high for two consecutive cycles.

Test Plan:
- Reset sequence: assert rst_n = 0 mid-PLAY with score1 = 5 → all outputs 0 immediately (asynchronous); after release, state IDLE and ball_en = 0.
- Start and serve: start held high 10 cycles → single serve_pulse one cycle later, ball_en = 1 the cycle after that, scores 0/0; no second serve.
- Point scoring: miss_p2 held high 5 cycles in PLAY → score1 = 1 once, ball_en = 0, serve_dir = 1. After 60 frame_ticks, serve_pulse, then PLAY.
- Speed ramp: 9 paddle_hit pulses, each 3 cycles wide → speed_lvl = 2. After a subsequent point and serve → speed_lvl = 0. 20 hits → saturates at 3.
- Simultaneous events: miss_p1 and miss_p2 rise on the same cycle → scores unchanged, PAUSE entered. miss_p1 together with paddle_hit → score2 +1 and the rally counter unchanged.
- Game end and restart: drive score2 from 10 with a miss_p1 event → score2 = 11, game_over = 1, winner = 1. Further miss events ignored. A start event → scores 0/0, game_over = 0, serve_dir = 0, serve_pulse asserted.

Source files
------------

// File: rtl/pong_game_fsm.sv
// rtl/pong_game_fsm.sv - pong game sequencer: edge events, scoring, serve/rally/pause/game-over
module pong_game_fsm #(
    parameter int SCORE_W        = 4,
    parameter int WIN_SCORE      = 11,
    parameter int PAUSE_FRAMES   = 60,
    parameter int PAUSE_W        = 6,
    parameter int HITS_PER_LEVEL = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               paddle_hit,
    input  logic               miss_p1,
    input  logic               miss_p2,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               ball_en,
    output logic               serve_pulse,
    output logic               serve_dir,
    output logic [1:0]         speed_lvl,
    output logic               game_over,
    output logic               winner
);

    localparam int RALLY_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_FRAMES - 1);
    localparam logic [RALLY_W-1:0] RALLY_LAST = RALLY_W'(HITS_PER_LEVEL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_PAUSE,
        S_GAME_OVER
    } state_t;

    state_t state, state_nxt;

    logic start_q, hit_q, miss1_q, miss2_q;
    logic start_ev, hit_ev, miss1_ev, miss2_ev;

    logic [RALLY_W-1:0] rally_cnt, rally_nxt;
    logic [PAUSE_W-1:0] pause_cnt, pause_nxt;
    logic [SCORE_W-1:0] score1_nxt, score2_nxt, score1_inc, score2_inc;
    logic [1:0]         speed_nxt;
    logic               serve_dir_nxt, winner_nxt;

    // Rising-edge events: a level held for many cycles produces one event
    always_comb begin
        start_ev = start & ~start_q;
        hit_ev   = paddle_hit & ~hit_q;
        miss1_ev = miss_p1 & ~miss1_q;
        miss2_ev = miss_p2 & ~miss2_q;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-value logic for scores, counters and serve direction
    always_comb begin
        state_nxt     = state;
        score1_nxt    = score1;
        score2_nxt    = score2;
        rally_nxt     = rally_cnt;
        pause_nxt     = pause_cnt;
        speed_nxt     = speed_lvl;
        serve_dir_nxt = serve_dir;
        winner_nxt    = winner;
        score1_inc    = score1 + SCORE_W'(1);
        score2_inc    = score2 + SCORE_W'(1);

        case (state)
            S_IDLE: begin
                if (start_ev) begin
                    score1_nxt    = '0;
                    score2_nxt    = '0;
                    serve_dir_nxt = 1'b0;
                    state_nxt     = S_SERVE;
                end
            end
            S_SERVE: begin
                rally_nxt = '0;
                speed_nxt = 2'd0;
                state_nxt = S_PLAY;
            end
            S_PLAY: begin
                // A miss always takes precedence over a same-cycle paddle hit
                if (miss1_ev && miss2_ev) begin
                    pause_nxt = '0;
                    state_nxt = S_PAUSE;
                end else if (miss1_ev) begin
                    score2_nxt    = score2_inc;
                    serve_dir_nxt = 1'b0;
                    if (score2_inc == WIN_VAL) begin
                        winner_nxt = 1'b1;
                        state_nxt  = S_GAME_OVER;
                    end else begin
                        pause_nxt = '0;
                        state_nxt = S_PAUSE;
                    end
                end else if (miss2_ev) begin
                    score1_nxt    = score1_inc;
                    serve_dir_nxt = 1'b1;
                    if (score1_inc == WIN_VAL) begin
                        winner_nxt = 1'b0;
                        state_nxt  = S_GAME_OVER;
                    end else begin
                        pause_nxt = '0;
                        state_nxt = S_PAUSE;
                    end
                end else if (hit_ev) begin
                    if (rally_cnt == RALLY_LAST) begin
                        rally_nxt = '0;
                        if (speed_lvl != 2'd3) begin
                            speed_nxt = speed_lvl + 2'd1;
                        end
                    end else begin
                        rally_nxt = rally_cnt + RALLY_W'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (frame_tick) begin
                    pause_nxt = pause_cnt + PAUSE_W'(1);
                    if (pause_cnt == PAUSE_LAST) begin
                        state_nxt = S_SERVE;
                    end
                end
            end
            S_GAME_OVER: begin
                // Loser of the finished game receives the first serve
                if (start_ev) begin
                    score1_nxt    = '0;
                    score2_nxt    = '0;
                    serve_dir_nxt = ~winner;
                    state_nxt     = S_SERVE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers; status outputs follow the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= 1'b0;
            hit_q       <= 1'b0;
            miss1_q     <= 1'b0;
            miss2_q     <= 1'b0;
            rally_cnt   <= '0;
            pause_cnt   <= '0;
            score1      <= '0;
            score2      <= '0;
            speed_lvl   <= 2'd0;
            serve_dir   <= 1'b0;
            winner      <= 1'b0;
            ball_en     <= 1'b0;
            serve_pulse <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            start_q     <= start;
            hit_q       <= paddle_hit;
            miss1_q     <= miss_p1;
            miss2_q     <= miss_p2;
            rally_cnt   <= rally_nxt;
            pause_cnt   <= pause_nxt;
            score1      <= score1_nxt;
            score2      <= score2_nxt;
            speed_lvl   <= speed_nxt;
            serve_dir   <= serve_dir_nxt;
            winner      <= winner_nxt;
            ball_en     <= (state_nxt == S_PLAY);
            serve_pulse <= (state_nxt == S_SERVE);
            game_over   <= (state_nxt == S_GAME_OVER);
        end
    end

endmodule

// File: tb/tb_pong_game_fsm.sv
// tb/tb_pong_game_fsm.sv - directed self-checking bench for pong_game_fsm
module tb_pong_game_fsm;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       start;
    logic       paddle_hit;
    logic       miss_p1;
    logic       miss_p2;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       ball_en;
    logic       serve_pulse;
    logic       serve_dir;
    logic [1:0] speed_lvl;
    logic       game_over;
    logic       winner;

    int n_vec;
    int n_err;
    int sp_count;

    pong_game_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .start       (start),
        .paddle_hit  (paddle_hit),
        .miss_p1     (miss_p1),
        .miss_p2     (miss_p2),
        .score1      (score1),
        .score2      (score2),
        .ball_en     (ball_en),
        .serve_pulse (serve_pulse),
        .serve_dir   (serve_dir),
        .speed_lvl   (speed_lvl),
        .game_over   (game_over),
        .winner      (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks, leaving the bench 1ns past the last rising edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hit_pulse();
        paddle_hit = 1'b1;
        cyc(3);
        paddle_hit = 1'b0;
        cyc(2);
    endtask

    // Sit out PAUSE: 60 frame ticks, then SERVE, then PLAY
    task automatic run_pause(input bit chk);
        cyc(1);
        repeat (59) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
        if (chk) begin
            check("pause_no_serve_59", serve_pulse, 1'b0);
            check("pause_ball_off", ball_en, 1'b0);
        end
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        if (chk) check("pause_serve_60", serve_pulse, 1'b1);
        cyc(1);
        if (chk) begin
            check("pause_play_ball", ball_en, 1'b1);
            check("pause_play_sp", serve_pulse, 1'b0);
        end
    endtask

    task automatic point(input bit p1_concedes);
        if (p1_concedes) miss_p1 = 1'b1;
        else             miss_p2 = 1'b1;
        cyc(1);
        miss_p1 = 1'b0;
        miss_p2 = 1'b0;
        run_pause(1'b0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        start      = 1'b0;
        paddle_hit = 1'b0;
        miss_p1    = 1'b0;
        miss_p2    = 1'b0;

        // Reset state
        cyc(2);
        check("rst_score1", score1, 0);
        check("rst_score2", score2, 0);
        check("rst_ball_en", ball_en, 0);
        check("rst_serve_pulse", serve_pulse, 0);
        check("rst_speed", speed_lvl, 0);
        check("rst_game_over", game_over, 0);
        rst_n = 1'b1;
        miss_p2 = 1'b1;
        cyc(2);
        miss_p2 = 1'b0;
        check("idle_miss_ignored", score1, 0);
        check("idle_ball_en", ball_en, 0);

        // Start held for 10 cycles: one serve, then play
        start = 1'b1;
        cyc(1);
        check("start_serve", serve_pulse, 1);
        check("start_ball_off", ball_en, 0);
        cyc(1);
        check("start_sp_drop", serve_pulse, 0);
        check("start_ball_on", ball_en, 1);
        sp_count = 0;
        repeat (8) begin
            cyc(1);
            if (serve_pulse) sp_count++;
        end
        start = 1'b0;
        check("start_no_reserve", sp_count, 0);
        check("start_scores", {score1, score2}, 0);

        // Speed ramp: 9 hits -> level 2
        for (int i = 1; i <= 9; i++) begin
            hit_pulse();
            if (i == 3) check("ramp_3_hits", speed_lvl, 0);
            if (i == 4) check("ramp_4_hits", speed_lvl, 1);
        end
        check("ramp_9_hits", speed_lvl, 2);

        // Player 2 misses (held 5 cycles): player 1 scores once
        miss_p2 = 1'b1;
        cyc(1);
        check("pt_score1", score1, 1);
        check("pt_ball_off", ball_en, 0);
        check("pt_serve_dir", serve_dir, 1);
        cyc(4);
        miss_p2 = 1'b0;
        check("pt_score1_held", score1, 1);
        // Events during PAUSE are dropped
        miss_p1 = 1'b1;
        start = 1'b1;
        paddle_hit = 1'b1;
        cyc(1);
        miss_p1 = 1'b0;
        start = 1'b0;
        paddle_hit = 1'b0;
        check("pause_miss_ignored", score2, 0);
        check("pause_start_ignored", serve_pulse, 0);
        run_pause(1'b1);
        check("serve_speed_clear", speed_lvl, 0);

        // Both misses together: no score change, direction kept, pause
        miss_p1 = 1'b1;
        miss_p2 = 1'b1;
        cyc(1);
        miss_p1 = 1'b0;
        miss_p2 = 1'b0;
        check("dbl_score1", score1, 1);
        check("dbl_score2", score2, 0);
        check("dbl_dir", serve_dir, 1);
        check("dbl_ball_off", ball_en, 0);
        run_pause(1'b0);

        // Miss with paddle hit: hit would have bumped the level, must not
        repeat (3) hit_pulse();
        check("mh_pre_speed", speed_lvl, 0);
        miss_p1 = 1'b1;
        paddle_hit = 1'b1;
        cyc(1);
        miss_p1 = 1'b0;
        paddle_hit = 1'b0;
        check("mh_score2", score2, 1);
        check("mh_speed", speed_lvl, 0);
        check("mh_dir", serve_dir, 0);
        run_pause(1'b0);

        // Saturation: 20 hits
        for (int i = 1; i <= 20; i++) begin
            hit_pulse();
            if (i == 12) check("sat_12_hits", speed_lvl, 3);
        end
        check("sat_20_hits", speed_lvl, 3);

        // Player 2 runs score up to 10, then wins on the next point
        repeat (9) point(1'b1);
        check("go_pre_score2", score2, 10);
        miss_p1 = 1'b1;
        cyc(1);
        miss_p1 = 1'b0;
        check("go_score2", score2, 11);
        check("go_flag", game_over, 1);
        check("go_winner", winner, 1);
        check("go_ball_off", ball_en, 0);
        miss_p2 = 1'b1;
        cyc(1);
        miss_p2 = 1'b0;
        repeat (70) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
        end
        check("go_hold_score1", score1, 1);
        check("go_hold_flag", game_over, 1);
        check("go_hold_winner", winner, 1);
        check("go_no_serve", serve_pulse, 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("rs_scores", {score1, score2}, 0);
        check("rs_flag", game_over, 0);
        check("rs_dir", serve_dir, 0);
        check("rs_serve", serve_pulse, 1);
        cyc(1);
        check("rs_ball_on", ball_en, 1);

        // Reset mid-play with score1 = 5 clears asynchronously
        repeat (5) point(1'b0);
        check("mid_score1", score1, 5);
        check("mid_ball_on", ball_en, 1);
        rst_n = 1'b0;
        #2;
        check("async_score1", score1, 0);
        check("async_ball_en", ball_en, 0);
        check("async_dir", serve_dir, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        check("post_rst_ball", ball_en, 0);
        check("post_rst_serve", serve_pulse, 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("post_rst_start", serve_pulse, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
